// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: shared AXI4-Lite slave types.
// Response codes, channel FSM states, strobe merge.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  localparam int MAX_DW = 64;
  localparam int MAX_SW = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] strb_merge(
    input logic [MAX_DW-1:0] old_d,
    input logic [MAX_DW-1:0] new_d,
    input logic [MAX_SW-1:0] strb
  );
    logic [MAX_DW-1:0] m;
    m = old_d;
    for (int i = 0; i < MAX_SW; i++) begin
      if (strb[i]) m[i*8 +: 8] = new_d[i*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/axi4lite_hold_reg.sv
// axi4lite_hold_reg: one-deep skid holder for a
// channel beat that arrived before its partner.
module axi4lite_hold_reg
  import axi4lite_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             held,
  output logic [WIDTH-1:0] q
);

  // capture payload on load, drop it once consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= 1'b0;
      q    <= '0;
    end else if (clear) begin
      held <= 1'b0;
    end else if (load) begin
      held <= 1'b1;
      q    <= d;
    end
  end

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// axi4lite_regfile_slave: AXI4-Lite register file
// with RO registers fed from hardware.
module axi4lite_regfile_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                         A_CLK,
  input  logic                         A_RST,
  input  logic                         AW_VALID,
  output logic                         AW_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]    AW_ADDR,
  input  logic [2:0]                   AW_PROT,
  input  logic                         W_VALID,
  output logic                         W_READY,
  input  logic [AXI_DATA_WIDTH-1:0]    W_DATA,
  input  logic [AXI_STRB_WIDTH-1:0]    W_STRB,
  output logic                         B_VALID,
  input  logic                         B_READY,
  output logic [1:0]                   B_RESP,
  input  logic                         AR_VALID,
  output logic                         AR_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]    AR_ADDR,
  input  logic [2:0]                   AR_PROT,
  output logic                         R_VALID,
  input  logic                         R_READY,
  output logic [AXI_DATA_WIDTH-1:0]    R_DATA,
  output logic [1:0]                   R_RESP,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] REG_OUT,
  input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] HW_IN,
  output logic [NUM_REGS-1:0]          WR_PULSE
);
  import axi4lite_pkg::*;

  localparam int AW  = AXI_ADDR_WIDTH;
  localparam int DW  = AXI_DATA_WIDTH;
  localparam int SW  = AXI_STRB_WIDTH;
  localparam int LSB = $clog2(SW);
  localparam int IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WHW = DW + SW;

  // {hit, index}; a borrow out of the subtraction means below base
  function automatic logic [IW:0] decode(
    input logic [AW-1:0] a
  );
    logic [AW:0]   diff;
    logic [AW-1:0] off;
    logic          hit;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    off  = diff[AW-1:0] >> LSB;
    hit  = !diff[AW] && (off < AW'(NUM_REGS));
    return {hit, off[IW-1:0]};
  endfunction

  wr_state_t wr_q, wr_d;
  rd_state_t rd_q, rd_d;

  logic aw_rdy_q, aw_rdy_d;
  logic w_rdy_q, w_rdy_d;
  logic ar_rdy_q, ar_rdy_d;
  logic b_vld_q, b_vld_d;
  logic r_vld_q, r_vld_d;
  resp_t b_rsp_q, b_rsp_d;
  resp_t r_rsp_q, r_rsp_d;
  logic [DW-1:0] r_dat_q, r_dat_d;
  logic [NUM_REGS-1:0] pls_q, pls_d;
  logic [DW-1:0] regs [NUM_REGS];

  logic aw_hs, w_hs, ar_hs;
  logic aw_held, w_held;
  logic aw_avail, w_avail;
  logic [AW-1:0] aw_q;
  logic [WHW-1:0] w_q;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [SW-1:0] ws;
  logic [IW:0] w_dec, r_dec;
  logic w_hit, r_hit;
  logic [IW-1:0] w_idx, r_idx;
  resp_t w_rsp;
  logic commit, wr_ok;
  logic [MAX_DW-1:0] mrg;
  logic unused_ok;

  assign aw_hs = AW_VALID && aw_rdy_q;
  assign w_hs  = W_VALID && w_rdy_q;
  assign ar_hs = AR_VALID && ar_rdy_q;

  assign aw_avail = aw_held || aw_hs;
  assign w_avail  = w_held || w_hs;
  assign commit   = (wr_q == W_IDLE) && aw_avail && w_avail;
  assign wr_ok    = commit && (w_rsp == OKAY);

  axi4lite_hold_reg #(.WIDTH(AW)) u_aw_hold (
    .clk   (A_CLK),
    .rst   (A_RST),
    .load  (aw_hs && !commit),
    .clear (commit),
    .d     (AW_ADDR),
    .held  (aw_held),
    .q     (aw_q)
  );

  axi4lite_hold_reg #(.WIDTH(WHW)) u_w_hold (
    .clk   (A_CLK),
    .rst   (A_RST),
    .load  (w_hs && !commit),
    .clear (commit),
    .d     ({W_DATA, W_STRB}),
    .held  (w_held),
    .q     (w_q)
  );

  // pick held or live beats and classify the write target
  always_comb begin
    wa = aw_held ? aw_q : AW_ADDR;
    {wd, ws} = w_held ? w_q : {W_DATA, W_STRB};
    w_dec = decode(wa);
    w_hit = w_dec[IW];
    w_idx = w_dec[IW-1:0];
    if (!w_hit) w_rsp = DECERR;
    else if (RO_MASK[w_idx]) w_rsp = SLVERR;
    else w_rsp = OKAY;
    mrg = strb_merge(MAX_DW'(regs[w_idx]),
                     MAX_DW'(wd), MAX_SW'(ws));
  end

  // write FSM next state
  always_comb begin
    wr_d = wr_q;
    unique case (wr_q)
      W_IDLE: if (commit) wr_d = W_RESP;
      W_RESP: if (B_READY) wr_d = W_IDLE;
    endcase
  end

  // write channel outputs, computed one cycle ahead
  always_comb begin
    b_vld_d = b_vld_q;
    b_rsp_d = b_rsp_q;
    pls_d   = '0;
    if (commit) begin
      b_vld_d = 1'b1;
      b_rsp_d = w_rsp;
      if (w_rsp == OKAY) pls_d[w_idx] = 1'b1;
    end else if (wr_q == W_RESP && B_READY) begin
      b_vld_d = 1'b0;
    end
    aw_rdy_d = (wr_d == W_IDLE) && !(aw_avail && !commit);
    w_rdy_d  = (wr_d == W_IDLE) && !(w_avail && !commit);
  end

  // write FSM state and registered write outputs
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      wr_q     <= W_IDLE;
      aw_rdy_q <= 1'b0;
      w_rdy_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      b_rsp_q  <= OKAY;
      pls_q    <= '0;
    end else begin
      wr_q     <= wr_d;
      aw_rdy_q <= aw_rdy_d;
      w_rdy_q  <= w_rdy_d;
      b_vld_q  <= b_vld_d;
      b_rsp_q  <= b_rsp_d;
      pls_q    <= pls_d;
    end
  end

  // register storage, strobed update on an OKAY commit
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[w_idx] <= mrg[DW-1:0];
    end
  end

  always_comb begin
    r_dec = decode(AR_ADDR);
    r_hit = r_dec[IW];
    r_idx = r_dec[IW-1:0];
  end

  // read FSM next state
  always_comb begin
    rd_d = rd_q;
    unique case (rd_q)
      R_IDLE: if (ar_hs) rd_d = axi4lite_pkg::R_DATA;
      axi4lite_pkg::R_DATA: if (R_READY) rd_d = R_IDLE;
    endcase
  end

  // read channel outputs; reads see pre-commit storage
  always_comb begin
    r_vld_d = r_vld_q;
    r_rsp_d = r_rsp_q;
    r_dat_d = r_dat_q;
    if (ar_hs) begin
      r_vld_d = 1'b1;
      r_rsp_d = r_hit ? OKAY : DECERR;
      if (!r_hit) r_dat_d = '0;
      else if (RO_MASK[r_idx])
        r_dat_d = HW_IN[r_idx*DW +: DW];
      else r_dat_d = regs[r_idx];
    end else if (rd_q == axi4lite_pkg::R_DATA && R_READY) begin
      r_vld_d = 1'b0;
    end
    ar_rdy_d = (rd_d == R_IDLE);
  end

  // read FSM state and registered read outputs
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      rd_q     <= R_IDLE;
      ar_rdy_q <= 1'b0;
      r_vld_q  <= 1'b0;
      r_rsp_q  <= OKAY;
      r_dat_q  <= '0;
    end else begin
      rd_q     <= rd_d;
      ar_rdy_q <= ar_rdy_d;
      r_vld_q  <= r_vld_d;
      r_rsp_q  <= r_rsp_d;
      r_dat_q  <= r_dat_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign REG_OUT[g*DW +: DW] = regs[g];
  end

  assign AW_READY = aw_rdy_q;
  assign W_READY  = w_rdy_q;
  assign AR_READY = ar_rdy_q;
  assign B_VALID  = b_vld_q;
  assign B_RESP   = b_rsp_q;
  assign R_VALID  = r_vld_q;
  assign R_RESP   = r_rsp_q;
  assign R_DATA   = r_dat_q;
  assign WR_PULSE = pls_q;

  assign unused_ok = ^{AW_PROT, AR_PROT, mrg};

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// tb_axi4lite_regfile_slave: vector table plus
// hand sequences for stalls, ordering and reset.
module tb_axi4lite_regfile_slave;

  logic clk = 1'b0;
  logic A_RST;
  logic AW_VALID, AW_READY;
  logic [31:0] AW_ADDR;
  logic [2:0] AW_PROT;
  logic W_VALID, W_READY;
  logic [31:0] W_DATA;
  logic [3:0] W_STRB;
  logic B_VALID, B_READY;
  logic [1:0] B_RESP;
  logic AR_VALID, AR_READY;
  logic [31:0] AR_ADDR;
  logic [2:0] AR_PROT;
  logic R_VALID, R_READY;
  logic [31:0] R_DATA;
  logic [1:0] R_RESP;
  logic [511:0] REG_OUT;
  logic [511:0] HW_IN;
  logic [15:0] WR_PULSE;

  int n_chk = 0;
  int n_pass = 0;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lag;
    logic [1:0]  rsp;
    logic [31:0] val;
    logic [15:0] pls;
    int          rchk;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  axi4lite_regfile_slave #(
    .NUM_REGS (16),
    .RO_MASK  (16'h0008)
  ) dut (
    .A_CLK    (clk),
    .A_RST    (A_RST),
    .AW_VALID (AW_VALID),
    .AW_READY (AW_READY),
    .AW_ADDR  (AW_ADDR),
    .AW_PROT  (AW_PROT),
    .W_VALID  (W_VALID),
    .W_READY  (W_READY),
    .W_DATA   (W_DATA),
    .W_STRB   (W_STRB),
    .B_VALID  (B_VALID),
    .B_READY  (B_READY),
    .B_RESP   (B_RESP),
    .AR_VALID (AR_VALID),
    .AR_READY (AR_READY),
    .AR_ADDR  (AR_ADDR),
    .AR_PROT  (AR_PROT),
    .R_VALID  (R_VALID),
    .R_READY  (R_READY),
    .R_DATA   (R_DATA),
    .R_RESP   (R_RESP),
    .REG_OUT  (REG_OUT),
    .HW_IN    (HW_IN),
    .WR_PULSE (WR_PULSE)
  );

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, req);
  endtask

  // lag > 0: W follows AW; lag < 0: W leads AW
  task automatic do_write(
    input logic [31:0] addr, input logic [31:0] data,
    input logic [3:0] strb, input int lag,
    input logic [1:0] rsp, input logic [15:0] pls,
    input int rchk, input logic [31:0] rval);
    int aw_at, w_at, cyc;
    bit aw_done, w_done, aw_go, w_go, viol, early;
    aw_at = (lag < 0) ? -lag : 0;
    w_at = (lag > 0) ? lag : 0;
    cyc = 0;
    aw_done = 0;
    w_done = 0;
    viol = 0;
    early = 0;
    exp_b.push_back(rsp);
    while (!(aw_done && w_done) && cyc < 50) begin
      if (cyc == aw_at) begin
        AW_VALID = 1'b1;
        AW_ADDR = addr;
      end
      if (cyc == w_at) begin
        W_VALID = 1'b1;
        W_DATA = data;
        W_STRB = strb;
      end
      if (aw_done == AW_READY) viol = 1;
      if (w_done == W_READY) viol = 1;
      if (B_VALID) early = 1;
      aw_go = AW_VALID && AW_READY;
      w_go = W_VALID && W_READY;
      @(negedge clk);
      cyc++;
      if (aw_go) begin
        AW_VALID = 1'b0;
        aw_done = 1;
      end
      if (w_go) begin
        W_VALID = 1'b0;
        w_done = 1;
      end
    end
    if (!(aw_done && w_done)) begin
      check("wr_timeout", 1, 0);
      AW_VALID = 1'b0;
      W_VALID = 1'b0;
      void'(exp_b.pop_back());
      return;
    end
    check("b_valid", B_VALID, 1);
    check("b_resp", B_RESP, exp_b.pop_front());
    check("wr_pulse", WR_PULSE, pls);
    if (rchk >= 0)
      check("reg_out", REG_OUT[rchk*32 +: 32], rval);
    check("rdy_order", {viol, early}, 0);
    if (B_READY) begin
      @(negedge clk);
      check("b_done_pulse_off",
            {B_VALID, WR_PULSE}, 0);
    end
  endtask

  task automatic do_read(input logic [31:0] addr,
                         input logic [1:0] rsp,
                         input logic [31:0] dat);
    int cyc;
    logic [33:0] e;
    cyc = 0;
    exp_r.push_back({rsp, dat});
    AR_VALID = 1'b1;
    AR_ADDR = addr;
    while (!AR_READY && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!AR_READY) begin
      check("rd_timeout", 1, 0);
      AR_VALID = 1'b0;
      void'(exp_r.pop_back());
      return;
    end
    @(negedge clk);
    AR_VALID = 1'b0;
    e = exp_r.pop_front();
    check("r_valid", R_VALID, 1);
    check("r_resp", R_RESP, e[33:32]);
    check("r_data", R_DATA, e[31:0]);
    if (R_READY) begin
      @(negedge clk);
      check("r_done", R_VALID, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [33:0] e;
    bit sv;
    tbl[0]  = '{1, 32'h04, 32'hDEADBEEF, 4'hF, 0,
                2'b00, 32'hDEADBEEF, 16'h0002, 1};
    tbl[1]  = '{0, 32'h04, 0, 0, 0,
                2'b00, 32'hDEADBEEF, 0, -1};
    tbl[2]  = '{1, 32'h08, 32'hFFFFFFFF, 4'hF, 0,
                2'b00, 32'hFFFFFFFF, 16'h0004, 2};
    tbl[3]  = '{1, 32'h0C, 32'h12345678, 4'hF, 1,
                2'b10, 32'h0, 16'h0000, 3};
    tbl[4]  = '{0, 32'h0C, 0, 0, 0,
                2'b00, 32'hCAFE0001, 0, -1};
    tbl[5]  = '{1, 32'h40, 32'hAAAA5555, 4'hF, 0,
                2'b11, 32'h0, 16'h0000, 0};
    tbl[6]  = '{0, 32'h40, 0, 0, 0,
                2'b11, 32'h0, 0, -1};
    tbl[7]  = '{1, 32'h05, 32'h000000AB, 4'h1, 2,
                2'b00, 32'hDEADBEAB, 16'h0002, 1};
    tbl[8]  = '{0, 32'h06, 0, 0, 0,
                2'b00, 32'hDEADBEAB, 0, -1};
    tbl[9]  = '{1, 32'h04, 32'h11111111, 4'h0, 0,
                2'b00, 32'hDEADBEAB, 16'h0002, 1};
    tbl[10] = '{0, 32'h04, 0, 0, 0,
                2'b00, 32'hDEADBEAB, 0, -1};
    tbl[11] = '{0, 32'h3C, 0, 0, 0,
                2'b00, 32'h0, 0, -1};
    tbl[12] = '{1, 32'h3F, 32'h0F0F0F0F, 4'hC, -1,
                2'b00, 32'h0F0F0000, 16'h8000, 15};
    tbl[13] = '{0, 32'h3C, 0, 0, 0,
                2'b00, 32'h0F0F0000, 0, -1};
    tbl[14] = '{0, 32'h08, 0, 0, 0,
                2'b00, 32'hFFFFFFFF, 0, -1};
    tbl[15] = '{0, 32'hFFFFFFFC, 0, 0, 0,
                2'b11, 32'h0, 0, -1};

    HW_IN = {16{32'hA5A5A5A5}};
    HW_IN[3*32 +: 32] = 32'hCAFE0001;
    A_RST = 1'b1;
    AW_VALID = 0; AW_ADDR = 0; AW_PROT = 0;
    W_VALID = 0; W_DATA = 0; W_STRB = 0;
    AR_VALID = 0; AR_ADDR = 0; AR_PROT = 0;
    B_READY = 1'b1;
    R_READY = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_ctrl", {AW_READY, W_READY, AR_READY,
          B_VALID, R_VALID, B_RESP, R_RESP}, 0);
    check("rst_data", {R_DATA, WR_PULSE}, 0);
    check("rst_regout", |REG_OUT, 0);
    A_RST = 1'b0;
    @(negedge clk);
    check("rdy_rise", {AW_READY, W_READY, AR_READY},
          3'b111);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr)
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb,
                 tbl[i].lag, tbl[i].rsp, tbl[i].pls,
                 tbl[i].rchk, tbl[i].val);
      else
        do_read(tbl[i].addr, tbl[i].rsp, tbl[i].val);
    end

    do_write(32'h08, 32'h11223344, 4'b0101, -3,
             2'b00, 16'h0004, 2, 32'hFF22FF44);

    exp_b.push_back(2'b00);
    exp_r.push_back({2'b00, 32'hDEADBEAB});
    check("same_rdy", {AW_READY, W_READY, AR_READY},
          3'b111);
    AW_VALID = 1; AW_ADDR = 32'h04;
    W_VALID = 1; W_DATA = 32'h77777777; W_STRB = 4'hF;
    AR_VALID = 1; AR_ADDR = 32'h04;
    @(negedge clk);
    AW_VALID = 0; W_VALID = 0; AR_VALID = 0;
    e = exp_r.pop_front();
    check("same_rdata", {R_VALID, R_RESP, R_DATA},
          {1'b1, e});
    check("same_b", {B_VALID, B_RESP},
          {1'b1, exp_b.pop_front()});
    check("same_reg", REG_OUT[1*32 +: 32], 32'h77777777);
    @(negedge clk);
    do_read(32'h04, 2'b00, 32'h77777777);

    B_READY = 1'b0;
    do_write(32'h10, 32'h44444444, 4'hF, 0,
             2'b00, 16'h0010, 4, 32'h44444444);
    sv = 0;
    repeat (5) begin
      @(negedge clk);
      if (!B_VALID || B_RESP != 2'b00 || AW_READY ||
          W_READY || WR_PULSE != 0) sv = 1;
    end
    check("b_stall", sv, 0);
    B_READY = 1'b1;
    @(negedge clk);
    check("b_release", {B_VALID, AW_READY, W_READY},
          3'b011);

    R_READY = 1'b0;
    do_read(32'h10, 2'b00, 32'h44444444);
    sv = 0;
    repeat (5) begin
      @(negedge clk);
      if (!R_VALID || R_DATA != 32'h44444444 ||
          R_RESP != 2'b00 || AR_READY) sv = 1;
    end
    check("r_stall", sv, 0);
    R_READY = 1'b1;
    @(negedge clk);
    check("r_release", R_VALID, 0);
    @(negedge clk);

    AW_VALID = 1; AW_ADDR = 32'h14;
    @(negedge clk);
    AW_VALID = 0;
    check("aw_held", {AW_READY, W_READY}, 2'b01);
    #2 A_RST = 1'b1;
    #1;
    check("mid_rst_ctrl", {AW_READY, W_READY, AR_READY,
          B_VALID, R_VALID, B_RESP, R_RESP}, 0);
    check("mid_rst_data", {R_DATA, WR_PULSE}, 0);
    check("mid_rst_regout", |REG_OUT, 0);
    @(negedge clk);
    A_RST = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", {AW_READY, W_READY, AR_READY,
          B_VALID}, 4'b1110);
    do_write(32'h14, 32'h12345655, 4'hF, 2,
             2'b00, 16'h0020, 5, 32'h12345655);
    do_read(32'h04, 2'b00, 32'h0);
    do_read(32'h14, 2'b00, 32'h12345655);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi4lite_regfile_slave.md
# axi4lite_regfile_slave

Parametrised AXI4-Lite slave register file: a generic, width/depth-configurable target behind the team's AXI4-Lite bus. It accepts AW and W independently and in any order, applies byte strobes, and returns OKAY/SLVERR/DECERR per register attribute and address decode. It exports register contents and per-register write pulses to hardware, and reads read-only registers from hardware inputs. It sits at the leaf of the interconnect as the standard control/status block for peripherals.

## Interface
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 32, data width; 32 or 64 only.
- NUM_REGS, 16, register count, ≥1.
- BASE_ADDR, 0, byte address of register 0; aligned to NUM_REGS*AXI_STRB_WIDTH rounded up to a power of two.
- RO_MASK, '0, NUM_REGS bits; bit i set makes register i read-only.
- AXI_STRB_WIDTH is derived as AXI_DATA_WIDTH/8 (localparam).

Ports, with "Already decided" as stated: one clock; reset is asynchronous and active-high.
- A_CLK  in  1  clock.
- A_RST  in  1  asynchronous, active-high reset.
- AW_VALID/AW_READY/AW_ADDR/AW_PROT, W_VALID/W_READY/W_DATA/W_STRB, B_VALID/B_READY/B_RESP, AR_VALID/AR_READY/AR_ADDR/AR_PROT, R_VALID/R_READY/R_DATA/R_RESP  slave direction  standard AXI4-Lite widths  bus channels. PROT is accepted and ignored.
- REG_OUT  out  NUM_REGS*AXI_DATA_WIDTH  writable register contents; register i occupies slice i.
- HW_IN  in  NUM_REGS*AXI_DATA_WIDTH  read value for read-only registers. Slices of writable registers are ignored.
- WR_PULSE  out  NUM_REGS  one-cycle strobe, asserted in the cycle after a committed OKAY write to register i.

## Operation
- Decode:
  - offset = ADDR − BASE_ADDR; index = offset >> log2(AXI_STRB_WIDTH).
  - Low byte bits are ignored; unaligned addresses are aligned down.
  - ADDR < BASE_ADDR or index ≥ NUM_REGS → DECERR (2'b11).
- Write path, states W_IDLE and W_RESP:
  - In W_IDLE, AW_READY = !aw_held and W_READY = !w_held. AW and W are captured into hold registers independently.
  - The write commits at the clock edge where both are available, whether each comes from its hold register or its current handshake.
  - Commit action: write the byte lanes with W_STRB set, assert B_VALID, set B_RESP, move to W_RESP, clear both hold flags.
  - Read-only target → SLVERR (2'b10), no update. Out of range → DECERR, no update.
  - W_STRB = 0 → OKAY, no data change, WR_PULSE still fires.
  - In W_RESP, AW_READY = W_READY = 0. B_VALID and B_RESP stay stable until B_READY; the block returns to W_IDLE on that edge.
- Read path, states R_IDLE and R_DATA:
  - In R_IDLE, AR_READY = 1. On handshake, register R_DATA/R_RESP and move to R_DATA with R_VALID = 1.
  - In R_DATA, AR_READY = 0. R_DATA/R_RESP stay stable until R_READY.
  - R_DATA source: writable register → stored value; read-only register → HW_IN sampled at the AR edge; DECERR → 0.
- Write and read paths are independent and run concurrently.

## Timing
- Reset (asynchronous, A_RST high) drives every output to 0: all READY, all VALID, all RESP, R_DATA, REG_OUT, WR_PULSE. Hold flags and both FSMs are cleared, including mid-transaction; a pending B or R response is dropped.
- READY signals are registered and rise in the first cycle after A_RST falls.
- Write latency: with the last of AW/W handshaking in cycle N, REG_OUT, WR_PULSE and B_VALID are all valid in cycle N+1. AW in cycle N and W in cycle N+3 gives commit at the end of N+3.
- Read latency: AR handshake in cycle N → R_VALID in cycle N+1.
- Throughput: at most one write per 2 cycles (B_READY tied high) and one read per 2 cycles.
- A write commit and an AR handshake on the same edge to the same register: the read returns the old value.
- VALID never depends combinationally on READY. No combinational input-to-output path exists.

## Structure
- Package axi4lite_pkg:
  - resp_t enum: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
  - Byte-strobe merge function.
- Sub-module axi4lite_hold_reg, parametrised by width: a valid flag plus payload register, instantiated once for AW (address) and once for W (data+strobe).

## Test plan
- Reset release, then AW 0x04 and W 0xDEADBEEF/4'hF in the same cycle → REG_OUT[1] = 0xDEADBEEF, WR_PULSE[1] one cycle, B_RESP OKAY next cycle; AR 0x04 → R_DATA 0xDEADBEEF.
- W first (0x11223344, strb 4'b0101) to register 2 holding 0xFFFFFFFF, AW 3 cycles later → 0xFF22FF44; AW_READY stays 1 until the AW handshake.
- RO_MASK[3] = 1, HW_IN[3] = 0xCAFE0001: write 0x0C → SLVERR, no WR_PULSE; read 0x0C → 0xCAFE0001 OKAY.
- NUM_REGS = 16, read/write 0x40 → DECERR, R_DATA 0, no register change.
- B_READY low for 5 cycles → B_VALID/B_RESP stable and AW_READY/W_READY low throughout; R_READY likewise holds R_DATA.
- Assert A_RST mid-write (AW held, W pending) → all outputs 0 immediately; after release, a fresh write completes normally.
